// File: rtl/irq_fifo_drain_ctrl.sv
// irq_fifo_drain_ctrl
// Drains the NI interrupt FIFO through its config-bus slave port. Each entry
// costs one single-cycle config read; the popped entry is then offered to the
// processor-side interrupt logic on a valid/ready port.
//
// Handshake (ent_valid / ent_ready): ent_valid rises only when a clean entry
// has been captured. ent_data and ent_src stay constant while ent_valid is
// high. The transfer completes on a rising edge where both ent_valid and
// ent_ready are high, and ent_valid is low in the following cycle.
//
// dbg_state exposes the FSM state: 0 = IDLE, 1 = READ, 2 = CAPTURE, 3 = OUT.
module irq_fifo_drain_ctrl #(
  parameter int ADDR_WIDTH  = 14,
  parameter int ENTRY_WIDTH = 14,
  parameter int DATA_ADDR   = 0,
  parameter int IRQ_ADDR    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   irq_irq_sig,
  input  logic                   irq_data_sig,
  output logic [ADDR_WIDTH-1:0]  config_addr,
  output logic                   config_en,
  output logic                   config_wr,
  output logic [31:0]            config_wdata,
  output logic                   sel,
  input  logic [31:0]            config_slv_rdata,
  input  logic                   config_slv_error,
  output logic                   ent_valid,
  input  logic                   ent_ready,
  output logic                   ent_src,
  output logic [ENTRY_WIDTH-1:0] ent_data,
  output logic                   err_pulse,
  output logic [7:0]             err_cnt,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_CAPTURE = 2'd2,
    S_OUT     = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   w_start;
  logic                   w_sel_src;
  logic                   r_cur_src;
  logic                   r_last_src;
  logic                   r_config_en;
  logic [ADDR_WIDTH-1:0]  r_config_addr;
  logic                   r_ent_valid;
  logic                   r_ent_src;
  logic [ENTRY_WIDTH-1:0] r_ent_data;
  logic                   r_err_pulse;
  logic [7:0]             r_err_cnt;
  logic                   w_unused_rdata;

  // Upper read-data bits beyond the entry width carry nothing for us.
  assign w_unused_rdata = ^config_slv_rdata;

  // Next-state logic and round-robin source selection.
  always_comb begin
    w_next_state = r_state;
    w_start      = enable && (irq_irq_sig || irq_data_sig);
    // On a tie take the queue that was not served last; otherwise the only
    // non-empty one.
    w_sel_src    = (irq_irq_sig && irq_data_sig) ? ~r_last_src : irq_irq_sig;
    case (r_state)
      S_IDLE:    if (w_start) w_next_state = S_READ;
      S_READ:    w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = config_slv_error ? S_IDLE : S_OUT;
      S_OUT:     if (ent_ready) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // State register plus registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cur_src     <= 1'b0;
      r_last_src    <= 1'b0;
      r_config_en   <= 1'b0;
      r_config_addr <= '0;
      r_ent_valid   <= 1'b0;
      r_ent_src     <= 1'b0;
      r_ent_data    <= '0;
      r_err_pulse   <= 1'b0;
      r_err_cnt     <= 8'd0;
    end else begin
      r_state     <= w_next_state;
      r_config_en <= (w_next_state == S_READ);
      // READ is only entered from IDLE, so w_sel_src is the source being read.
      if (w_next_state == S_READ)
        r_config_addr <= w_sel_src ? ADDR_WIDTH'(IRQ_ADDR) : ADDR_WIDTH'(DATA_ADDR);
      else
        r_config_addr <= '0;
      if (r_state == S_IDLE && w_start) begin
        r_cur_src  <= w_sel_src;
        r_last_src <= w_sel_src;
      end
      r_ent_valid <= (w_next_state == S_OUT);
      if (r_state == S_CAPTURE && !config_slv_error) begin
        r_ent_data <= config_slv_rdata[ENTRY_WIDTH-1:0];
        r_ent_src  <= r_cur_src;
      end
      r_err_pulse <= (r_state == S_CAPTURE) && config_slv_error;
      if (r_state == S_CAPTURE && config_slv_error && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign config_addr  = r_config_addr;
  assign config_en    = r_config_en;
  assign sel          = r_config_en;
  assign config_wr    = 1'b0;
  assign config_wdata = 32'd0;
  assign ent_valid    = r_ent_valid;
  assign ent_src      = r_ent_src;
  assign ent_data     = r_ent_data;
  assign err_pulse    = r_err_pulse;
  assign err_cnt      = r_err_cnt;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_irq_fifo_drain_ctrl.sv
// Directed bench for irq_fifo_drain_ctrl. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_irq_fifo_drain_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        irq_irq_sig = 1'b0;
  logic        irq_data_sig = 1'b0;
  logic [13:0] config_addr;
  logic        config_en;
  logic        config_wr;
  logic [31:0] config_wdata;
  logic        sel;
  logic [31:0] config_slv_rdata = 32'd0;
  logic        config_slv_error = 1'b0;
  logic        ent_valid;
  logic        ent_ready = 1'b0;
  logic        ent_src;
  logic [13:0] ent_data;
  logic        err_pulse;
  logic [7:0]  err_cnt;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  irq_fifo_drain_ctrl #(
    .ADDR_WIDTH(14), .ENTRY_WIDTH(14), .DATA_ADDR(0), .IRQ_ADDR(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .irq_irq_sig(irq_irq_sig), .irq_data_sig(irq_data_sig),
    .config_addr(config_addr), .config_en(config_en), .config_wr(config_wr),
    .config_wdata(config_wdata), .sel(sel),
    .config_slv_rdata(config_slv_rdata), .config_slv_error(config_slv_error),
    .ent_valid(ent_valid), .ent_ready(ent_ready), .ent_src(ent_src),
    .ent_data(ent_data), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .dbg_state(dbg_state)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  // Every output must sit at its reset value.
  task automatic check_reset_values(input string tag);
    checks++;
    if ({config_en, sel, config_wr, ent_valid, ent_src, err_pulse} !== 6'b0 ||
        config_addr !== 14'd0 || config_wdata !== 32'd0 || ent_data !== 14'd0 ||
        err_cnt !== 8'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL %s: en=%b sel=%b wr=%b addr=%0d wdata=%h valid=%b src=%b data=%h pulse=%b cnt=%0d st=%0d, required all zero",
               tag, config_en, sel, config_wr, config_addr, config_wdata, ent_valid,
               ent_src, ent_data, err_pulse, err_cnt, dbg_state);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step(); step();
    check_reset_values("reset_values");
    reset = 1'b0;
    step();
    check_reset_values("idle_after_reset");
  endtask

  task automatic test_single_irq();
    enable = 1'b1; ent_ready = 1'b1; config_slv_error = 1'b0;
    config_slv_rdata = 32'h0000_02A5;
    irq_irq_sig = 1'b1;                 // cycle t (IDLE)
    step();                             // t+1: READ
    checks++;
    if (config_en !== 1'b1 || sel !== 1'b1 || config_addr !== 14'd1 || config_wr !== 1'b0) begin
      errors++;
      $display("FAIL single_strobe: en=%b sel=%b addr=%0d wr=%b, required 1 1 1 0", config_en, sel, config_addr, config_wr);
    end
    irq_irq_sig = 1'b0;                 // popped
    step();                             // t+2: CAPTURE
    checks++;
    if (config_en !== 1'b0 || config_addr !== 14'd0 || ent_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_capture: en=%b addr=%0d valid=%b, required 0 0 0", config_en, config_addr, ent_valid);
    end
    step();                             // t+3: OUT
    checks++;
    if (ent_valid !== 1'b1 || ent_data !== 14'h2A5 || ent_src !== 1'b1) begin
      errors++;
      $display("FAIL single_entry: valid=%b data=%h src=%b, required 1 2a5 1", ent_valid, ent_data, ent_src);
    end
    step();                             // handshake done
    checks++;
    if (ent_valid !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL single_release: valid=%b st=%0d, required 0 0", ent_valid, dbg_state);
    end
    begin
      int strobes = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (config_en) strobes++;
      end
      checks++;
      if (strobes !== 0) begin
        errors++;
        $display("FAIL single_no_reread: strobes=%0d, required 0", strobes);
      end
    end
  endtask

  task automatic test_tie_arbitration();
    int strobes = 0;
    int last_cyc = -1;
    logic [13:0] exp_addr;
    do_reset();
    enable = 1'b1; ent_ready = 1'b1; config_slv_error = 1'b0;
    config_slv_rdata = 32'h0000_0111;
    irq_irq_sig = 1'b1; irq_data_sig = 1'b1;   // cycle 0
    exp_addr = 14'd1;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 16) begin
        irq_irq_sig = 1'b0; irq_data_sig = 1'b0;
      end
      if (config_en) begin
        checks++;
        if (config_addr !== exp_addr) begin
          errors++;
          $display("FAIL tie_addr: strobe %0d addr=%0d, required %0d", strobes, config_addr, exp_addr);
        end
        if (last_cyc >= 0) begin
          checks++;
          if (c - last_cyc !== 4) begin
            errors++;
            $display("FAIL tie_spacing: spacing=%0d, required 4", c - last_cyc);
          end
        end
        last_cyc = c;
        strobes++;
        exp_addr = (exp_addr == 14'd1) ? 14'd0 : 14'd1;
      end
      if (ent_valid) begin
        checks++;
        // the source delivered is the opposite of the next expected address
        if (ent_src !== ~exp_addr[0]) begin
          errors++;
          $display("FAIL tie_src: src=%b, required %b", ent_src, ~exp_addr[0]);
        end
      end
    end
    checks++;
    if (strobes !== 4) begin
      errors++;
      $display("FAIL tie_count: strobes=%0d, required 4", strobes);
    end
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    enable = 1'b1; ent_ready = 1'b0; config_slv_error = 1'b0;
    config_slv_rdata = 32'h0000_1234;
    irq_data_sig = 1'b1;                // t
    step();                             // t+1
    checks++;
    if (config_en !== 1'b1 || config_addr !== 14'd0) begin
      errors++;
      $display("FAIL bp_strobe: en=%b addr=%0d, required 1 0", config_en, config_addr);
    end
    irq_data_sig = 1'b0;
    step(); step();                     // t+3: OUT
    irq_irq_sig = 1'b1;                 // pending work must wait for the stall
    config_slv_rdata = 32'h0000_0555;
    for (int i = 0; i < 10; i++) begin
      if (ent_valid !== 1'b1 || ent_data !== 14'h1234 || ent_src !== 1'b0 || config_en !== 1'b0) begin
        bad++;
        $display("FAIL bp_stall: cycle %0d valid=%b data=%h src=%b en=%b, required 1 1234 0 0", i, ent_valid, ent_data, ent_src, config_en);
      end
      step();
    end
    checks++;
    if (bad !== 0) errors++;
    ent_ready = 1'b1;                   // OUT with ready
    irq_irq_sig = 1'b0;
    step();
    checks++;
    if (ent_valid !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL bp_release: valid=%b st=%0d, required 0 0", ent_valid, dbg_state);
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_slave_error();
    int pulses = 1;
    int cyc = 0;
    enable = 1'b1; ent_ready = 1'b1; config_slv_error = 1'b1;
    irq_irq_sig = 1'b1;                 // t
    step();                             // t+1
    irq_irq_sig = 1'b0;
    step();                             // t+2
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL err_early: pulse=%b, required 0", err_pulse);
    end
    step();                             // t+3
    checks++;
    if (err_pulse !== 1'b1 || err_cnt !== 8'd1 || ent_valid !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL err_first: pulse=%b cnt=%0d valid=%b st=%0d, required 1 1 0 0", err_pulse, err_cnt, ent_valid, dbg_state);
    end
    step();
    checks++;
    if (err_pulse !== 1'b0 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL err_one_cycle: pulse=%b cnt=%0d, required 0 1", err_pulse, err_cnt);
    end
    // 299 further errors with the IRQ queue kept non-empty
    irq_irq_sig = 1'b1;
    while (pulses < 300 && cyc < 2000) begin
      step();
      cyc++;
      if (err_pulse) begin
        pulses++;
        if (pulses == 10) begin
          checks++;
          if (err_cnt !== 8'd10) begin
            errors++;
            $display("FAIL err_count10: cnt=%0d, required 10", err_cnt);
          end
        end
        if (pulses == 300) irq_irq_sig = 1'b0;
      end
    end
    checks++;
    if (pulses !== 300) begin
      errors++;
      $display("FAIL err_timeout: pulses=%0d, required 300", pulses);
    end
    irq_irq_sig = 1'b0;
    step(); step(); step(); step();
    checks++;
    if (err_cnt !== 8'd255 || ent_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_saturate: cnt=%0d valid=%b, required 255 0", err_cnt, ent_valid);
    end
    config_slv_error = 1'b0;
  endtask

  task automatic test_enable_gating();
    int strobes = 0;
    enable = 1'b0; ent_ready = 1'b1; config_slv_error = 1'b0;
    config_slv_rdata = 32'h0000_00AB;
    irq_irq_sig = 1'b1; irq_data_sig = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (config_en) strobes++;
    end
    checks++;
    if (strobes !== 0) begin
      errors++;
      $display("FAIL en_gate: strobes=%0d, required 0", strobes);
    end
    irq_irq_sig = 1'b0;
    enable = 1'b1;                      // t, data queue only
    step();                             // t+1
    checks++;
    if (config_en !== 1'b1 || config_addr !== 14'd0) begin
      errors++;
      $display("FAIL en_strobe: en=%b addr=%0d, required 1 0", config_en, config_addr);
    end
    enable = 1'b0;                      // dropped during READ
    step(); step();                     // t+3
    checks++;
    if (ent_valid !== 1'b1 || ent_data !== 14'h0AB || ent_src !== 1'b0) begin
      errors++;
      $display("FAIL en_deliver: valid=%b data=%h src=%b, required 1 0ab 0", ent_valid, ent_data, ent_src);
    end
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (config_en) strobes++;
    end
    checks++;
    if (strobes !== 0) begin
      errors++;
      $display("FAIL en_stop: strobes=%0d, required 0", strobes);
    end
    irq_data_sig = 1'b0;
  endtask

  task automatic test_reset_in_capture();
    enable = 1'b1; ent_ready = 1'b1; config_slv_error = 1'b0;
    config_slv_rdata = 32'h0000_03FF;
    irq_irq_sig = 1'b1;                 // t
    step();                             // t+1
    irq_irq_sig = 1'b0;
    step();                             // t+2: CAPTURE
    checks++;
    if (dbg_state !== 2'd2) begin
      errors++;
      $display("FAIL rst_in_capture: st=%0d, required 2", dbg_state);
    end
    reset = 1'b1;
    step();                             // t+3
    check_reset_values("rst_mid_op");
    reset = 1'b0;
    irq_data_sig = 1'b1;                // IDLE evaluation cycle
    step();
    checks++;
    if (config_en !== 1'b1 || config_addr !== 14'd0) begin
      errors++;
      $display("FAIL rst_resume: en=%b addr=%0d, required 1 0", config_en, config_addr);
    end
    irq_data_sig = 1'b0;
    step(); step();
    checks++;
    if (ent_valid !== 1'b1 || ent_data !== 14'h3FF || ent_src !== 1'b0) begin
      errors++;
      $display("FAIL rst_entry: valid=%b data=%h src=%b, required 1 3ff 0", ent_valid, ent_data, ent_src);
    end
    step(); step();
  endtask

  initial begin
    test_reset();
    test_single_irq();
    test_tie_arbitration();
    test_backpressure();
    test_slave_error();
    test_enable_gating();
    test_reset_in_capture();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
